// File: rtl/sdram_arbit_if.sv
// SDRAM arbiter bundle: engine command/address buses, bus grants, and the muxed pin-side outputs.
// Latency: none. This file holds only wires.
// Backpressure: the grants (aref_en/wr_en/rd_en) are the only flow control; engines obey them.
interface sdram_arbit_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;

    logic        aref_en;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;

    logic        wr_ask;
    logic        wr_en;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;

    logic        rd_ask;
    logic        rd_en;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;

    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic        sdram_dq_oe;
    logic        ref_overrun;

    // Arbiter side: owns the grants and the pin-side bus.
    modport master (
        input  init_end, init_cmd, init_addr,
        input  aref_end, aref_cmd, aref_addr,
        input  wr_ask, wr_end, wr_cmd, wr_addr, wr_bank,
        input  rd_ask, rd_end, rd_cmd, rd_addr, rd_bank,
        output aref_en, wr_en, rd_en,
        output sdram_cmd, sdram_addr, sdram_bank, sdram_dq_oe, ref_overrun
    );

    // Engine and pin side.
    modport slave (
        output init_end, init_cmd, init_addr,
        output aref_end, aref_cmd, aref_addr,
        output wr_ask, wr_end, wr_cmd, wr_addr, wr_bank,
        output rd_ask, rd_end, rd_cmd, rd_addr, rd_bank,
        input  aref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_addr, sdram_bank, sdram_dq_oe, ref_overrun
    );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM arbiter: grants the shared command bus to init/refresh/write/read engines; owns the refresh timer.
// Latency: the pin mux is zero-latency from registered state; a grant follows its ask by one IDLE cycle.
// Backpressure: a pending refresh drops wr_en/rd_en at once; the owner keeps the bus until its *_end pulse.
module sdram_arbit #(
    parameter int REF_PERIOD = 750,
    parameter int CNT_W      = 10
) (
    input  logic          sclk,
    input  logic          srst,
    sdram_arbit_if.master bus
);

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_IDLE  = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_PERIOD - 1);

    state_t           state_q;
    logic             last_wr_q;   // 1: last data grant went to WRITE, 0: to READ
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_req_q, ref_req_d;
    logic             ref_ovr_q, ref_ovr_d;
    logic             expire;

    // Refresh timer next-state: frozen at 0 during INIT. Expiry sets the request and wins over aref_end.
    always_comb begin
        expire    = (state_q != ST_INIT) && (ref_cnt_q == CNT_MAX);
        ref_cnt_d = ref_cnt_q;
        ref_req_d = ref_req_q;
        ref_ovr_d = ref_ovr_q | (expire & ref_req_q);
        if (state_q == ST_INIT) begin
            ref_cnt_d = '0;
        end else if (expire) begin
            ref_cnt_d = '0;
        end else begin
            ref_cnt_d = ref_cnt_q + CNT_W'(1);
        end
        if ((state_q == ST_AREF) && bus.aref_end) begin
            ref_req_d = 1'b0;
        end
        if (expire) begin
            ref_req_d = 1'b1;
        end
    end

    // Refresh timer, request and sticky overrun registers.
    always_ff @(posedge sclk) begin
        if (srst) begin
            ref_cnt_q <= '0;
            ref_req_q <= 1'b0;
            ref_ovr_q <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            ref_req_q <= ref_req_d;
            ref_ovr_q <= ref_ovr_d;
        end
    end

    // Bus ownership FSM: every grant returns through IDLE; refresh beats data; write/read alternate on a tie.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q   <= ST_INIT;
            last_wr_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_INIT:  if (bus.init_end) state_q <= ST_IDLE;
                ST_IDLE: begin
                    if (ref_req_q) begin
                        state_q <= ST_AREF;
                    end else if (bus.wr_ask && (!bus.rd_ask || !last_wr_q)) begin
                        state_q   <= ST_WRITE;
                        last_wr_q <= 1'b1;
                    end else if (bus.rd_ask) begin
                        state_q   <= ST_READ;
                        last_wr_q <= 1'b0;
                    end
                end
                ST_AREF:  if (bus.aref_end) state_q <= ST_IDLE;
                ST_WRITE: if (bus.wr_end)   state_q <= ST_IDLE;
                ST_READ:  if (bus.rd_end)   state_q <= ST_IDLE;
                default:  state_q <= ST_INIT;
            endcase
        end
    end

    // Grants and pin mux decoded straight from the registered state.
    always_comb begin
        bus.aref_en     = (state_q == ST_AREF);
        bus.wr_en       = (state_q == ST_WRITE) && !ref_req_q;
        bus.rd_en       = (state_q == ST_READ)  && !ref_req_q;
        bus.sdram_dq_oe = (state_q == ST_WRITE);
        bus.ref_overrun = ref_ovr_q;
        bus.sdram_cmd   = 4'b0111;
        bus.sdram_addr  = 12'h000;
        bus.sdram_bank  = 2'b00;
        unique case (state_q)
            ST_INIT: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            ST_AREF: begin
                bus.sdram_cmd  = bus.aref_cmd;
                bus.sdram_addr = bus.aref_addr;
            end
            ST_WRITE: begin
                bus.sdram_cmd  = bus.wr_cmd;
                bus.sdram_addr = bus.wr_addr;
                bus.sdram_bank = bus.wr_bank;
            end
            ST_READ: begin
                bus.sdram_cmd  = bus.rd_cmd;
                bus.sdram_addr = bus.rd_addr;
                bus.sdram_bank = bus.rd_bank;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: scripted vectors, refresh/overrun/reset corner sequences, then random traffic.
// Latency: outputs are sampled 1 ns after each rising edge, and inputs change right after sampling.
// Backpressure: the engines are modelled only by their ask/end pulses; grants are checked, not obeyed.
module tb_sdram_arbit;
    localparam int P = 16;
    localparam int OWN_INIT = 0, OWN_IDLE = 1, OWN_AREF = 2, OWN_WR = 3, OWN_RD = 4;

    logic sclk = 1'b0;
    logic srst;
    sdram_arbit_if bus();

    sdram_arbit #(.REF_PERIOD(P), .CNT_W(5)) dut (.sclk(sclk), .srst(srst), .bus(bus));

    always #5 sclk = ~sclk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic srst, ie, ae, wa, ra, we, re;
        int   exp_own;
    } vec_t;

    // Reference model state
    int   m_own, m_elapsed;
    logic m_req, m_ovr, m_lastwr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {aref_en, wr_en, rd_en, dq_oe, ref_overrun}
    function automatic logic [4:0] grants_exp(input int own, input logic req, input logic ovr);
        return {own == OWN_AREF, (own == OWN_WR) && !req, (own == OWN_RD) && !req, own == OWN_WR, ovr};
    endfunction

    function automatic logic [4:0] grants_act();
        return {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_dq_oe, bus.ref_overrun};
    endfunction

    function automatic logic [17:0] bus_exp(input int own);
        case (own)
            OWN_INIT: return {bus.init_cmd, bus.init_addr, 2'b00};
            OWN_AREF: return {bus.aref_cmd, bus.aref_addr, 2'b00};
            OWN_WR:   return {bus.wr_cmd, bus.wr_addr, bus.wr_bank};
            OWN_RD:   return {bus.rd_cmd, bus.rd_addr, bus.rd_bank};
            default:  return {4'b0111, 12'h000, 2'b00};
        endcase
    endfunction

    task automatic check_all(input string tag, input int own, input logic req, input logic ovr);
        chk({tag, "/grants"}, 32'(grants_act()), 32'(grants_exp(own, req, ovr)));
        chk({tag, "/bus"}, 32'({bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank}), 32'(bus_exp(own)));
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic clear_in();
        srst = 1'b0;
        bus.init_end = 0; bus.aref_end = 0;
        bus.wr_ask = 0; bus.wr_end = 0; bus.rd_ask = 0; bus.rd_end = 0;
        bus.init_cmd = 4'h1; bus.init_addr = 12'h111;
        bus.aref_cmd = 4'h2; bus.aref_addr = 12'h222;
        bus.wr_cmd = 4'h4; bus.wr_addr = 12'h444; bus.wr_bank = 2'd1;
        bus.rd_cmd = 4'b0101; bus.rd_addr = 12'h555; bus.rd_bank = 2'd2;
    endtask

    task automatic reset_and_init();
        srst = 1; tick(); tick(); srst = 0;
        bus.init_end = 1; tick(); bus.init_end = 0;
    endtask

    task automatic wait_aref(output int n, input int limit);
        n = 0;
        while (!bus.aref_en && n < limit) begin
            tick();
            n++;
        end
    endtask

    // One clock edge of the reference model. The refresh instants are multiples of P edges after leaving INIT.
    task automatic model_step();
        logic ex;
        int   nxt;
        if (srst) begin
            m_own = OWN_INIT; m_req = 0; m_ovr = 0; m_elapsed = 0; m_lastwr = 0;
        end else begin
            ex  = (m_own != OWN_INIT) && (((m_elapsed + 1) % P) == 0);
            nxt = m_own;
            case (m_own)
                OWN_INIT: if (bus.init_end) nxt = OWN_IDLE;
                OWN_IDLE: begin
                    if (m_req) nxt = OWN_AREF;
                    else if (bus.wr_ask && bus.rd_ask) nxt = m_lastwr ? OWN_RD : OWN_WR;
                    else if (bus.wr_ask) nxt = OWN_WR;
                    else if (bus.rd_ask) nxt = OWN_RD;
                end
                OWN_AREF: if (bus.aref_end) nxt = OWN_IDLE;
                OWN_WR:   if (bus.wr_end)   nxt = OWN_IDLE;
                default:  if (bus.rd_end)   nxt = OWN_IDLE;
            endcase
            if (m_own == OWN_IDLE && nxt == OWN_WR) m_lastwr = 1;
            if (m_own == OWN_IDLE && nxt == OWN_RD) m_lastwr = 0;
            if (ex && m_req) m_ovr = 1;
            if (m_own == OWN_AREF && bus.aref_end) m_req = 0;
            if (ex) m_req = 1;
            if (m_own != OWN_INIT) m_elapsed++;
            m_own = nxt;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   n, seen;

        clear_in();
        srst = 1;
        #2;

        // Scripted arbitration walk: reset, INIT immunity, round-robin, ignored stray *_end pulses.
        tbl.push_back('{1,0,0,0,0,0,0, OWN_INIT});
        tbl.push_back('{1,0,0,0,0,0,0, OWN_INIT});
        tbl.push_back('{0,0,0,0,0,0,0, OWN_INIT});
        tbl.push_back('{0,0,0,1,1,0,0, OWN_INIT});
        tbl.push_back('{0,0,1,1,1,1,1, OWN_INIT});
        tbl.push_back('{0,1,0,1,1,0,0, OWN_IDLE});
        tbl.push_back('{0,0,0,1,1,0,0, OWN_WR});
        tbl.push_back('{0,0,0,1,1,0,1, OWN_WR});
        tbl.push_back('{0,0,0,1,1,1,0, OWN_IDLE});
        tbl.push_back('{0,0,0,1,1,0,0, OWN_RD});
        tbl.push_back('{0,0,1,1,1,1,0, OWN_RD});
        tbl.push_back('{0,0,0,1,1,0,1, OWN_IDLE});
        tbl.push_back('{0,0,0,1,1,0,0, OWN_WR});
        tbl.push_back('{0,0,0,0,0,1,0, OWN_IDLE});
        tbl.push_back('{0,0,0,0,0,0,0, OWN_IDLE});
        tbl.push_back('{0,0,0,0,1,0,0, OWN_RD});
        tbl.push_back('{0,0,0,0,0,0,1, OWN_IDLE});
        tbl.push_back('{0,0,0,1,0,0,0, OWN_WR});
        tbl.push_back('{0,0,0,1,1,1,0, OWN_IDLE});
        tbl.push_back('{0,0,0,0,1,0,0, OWN_RD});
        foreach (tbl[i]) begin
            srst = tbl[i].srst; bus.init_end = tbl[i].ie; bus.aref_end = tbl[i].ae;
            bus.wr_ask = tbl[i].wa; bus.rd_ask = tbl[i].ra;
            bus.wr_end = tbl[i].we; bus.rd_end = tbl[i].re;
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].exp_own, 1'b0, 1'b0);
        end

        // Long INIT: no refresh while waiting, then NOP in IDLE.
        clear_in();
        srst = 1; tick(); tick(); srst = 0;
        check_all("t1_reset", OWN_INIT, 0, 0);
        seen = 0;
        for (int c = 3; c < 200; c++) begin
            tick();
            if (bus.aref_en) seen++;
        end
        chk("t1_no_aref_in_init", 32'(seen), 32'd0);
        bus.init_end = 1; tick(); bus.init_end = 0;
        check_all("t1_idle", OWN_IDLE, 0, 0);

        // First refresh P+1 edges after leaving INIT.
        wait_aref(n, 100);
        chk("t2_ref_delay", 32'(n), 32'(P + 1));
        check_all("t2_aref", OWN_AREF, 1, 0);
        bus.aref_end = 1; tick(); bus.aref_end = 0;
        check_all("t2_after_aref_end", OWN_IDLE, 0, 0);

        // Refresh interrupts a write granted at timer count 5.
        clear_in();
        reset_and_init();
        for (int k = 1; k <= 4; k++) tick();
        bus.wr_ask = 1; tick();
        check_all("t4_wr_grant", OWN_WR, 0, 0);
        for (int k = 6; k <= 15; k++) tick();
        check_all("t4_wr_before_ref", OWN_WR, 0, 0);
        tick();
        check_all("t4_wr_dropped", OWN_WR, 1, 0);
        for (int k = 17; k <= 21; k++) tick();
        check_all("t4_wr_held", OWN_WR, 1, 0);
        bus.wr_end = 1; tick(); bus.wr_end = 0;
        check_all("t4_idle", OWN_IDLE, 1, 0);
        tick();
        check_all("t4_aref", OWN_AREF, 1, 0);
        bus.aref_end = 1; tick(); bus.aref_end = 0;
        check_all("t4_idle2", OWN_IDLE, 0, 0);
        tick();
        check_all("t4_regrant", OWN_WR, 0, 0);

        // Overrun on the second expiry with no aref_end; sticky afterwards.
        clear_in();
        reset_and_init();
        wait_aref(n, 100);
        chk("t5_ref_delay", 32'(n), 32'(P + 1));
        for (int k = P + 2; k < 2 * P; k++) tick();
        check_all("t5_before_2nd", OWN_AREF, 1, 0);
        tick();
        check_all("t5_overrun", OWN_AREF, 1, 1);
        bus.aref_end = 1; tick(); bus.aref_end = 0;
        check_all("t5_sticky", OWN_IDLE, 0, 1);

        // Reset in the middle of a read clears everything, and the timer restarts from 0.
        bus.rd_ask = 1; tick();
        check_all("t6_read", OWN_RD, 0, 1);
        srst = 1; tick(); srst = 0; bus.rd_ask = 0;
        check_all("t6_reset", OWN_INIT, 0, 0);
        bus.init_end = 1; tick(); bus.init_end = 0;
        wait_aref(n, 100);
        chk("t6_cnt_cleared", 32'(n), 32'(P + 1));

        // Random traffic against the reference model.
        srst = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            model_step();
            check_all("rnd", m_own, m_req, m_ovr);
            srst          = ($urandom_range(0, 199) == 0);
            bus.init_end  = ($urandom_range(0, 7) == 0);
            bus.aref_end  = ($urandom_range(0, 5) == 0);
            bus.wr_end    = ($urandom_range(0, 5) == 0);
            bus.rd_end    = ($urandom_range(0, 5) == 0);
            bus.wr_ask    = ($urandom_range(0, 2) != 0);
            bus.rd_ask    = ($urandom_range(0, 2) != 0);
            bus.init_cmd  = 4'($urandom);  bus.init_addr = 12'($urandom);
            bus.aref_cmd  = 4'($urandom);  bus.aref_addr = 12'($urandom);
            bus.wr_cmd    = 4'($urandom);  bus.wr_addr   = 12'($urandom); bus.wr_bank = 2'($urandom);
            bus.rd_cmd    = 4'($urandom);  bus.rd_addr   = 12'($urandom); bus.rd_bank = 2'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
